clk_gen_tune_ctrl: RTL

- Calibration controller for the tunable ring-oscillator clock generator.
- Drives the stage-select code that chooses how many delay stages sit in the oscillator loop.
- Measures the resulting oscillator frequency against the reference clock by counting edges over a fixed window.
- Runs a successive-approximation (binary) search for the slowest tap setting whose edge count still meets a target, then reports the result and a lock flag.

---
 rtl/clk_gen_tune_ctrl_if.sv | 25 ++
 rtl/clk_gen_tune_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/clk_gen_tune_ctrl_if.sv
// Handshake and oscillator-control bundle between the clock-generator calibration
// controller (slave) and whoever starts calibration and drives the oscillator tap (master).
interface clk_gen_tune_ctrl_if #(
    parameter int SEL_W = 4,
    parameter int CNT_W = 12
);
    logic             start_i;
    logic [CNT_W-1:0] target_count_i;
    logic             osc_toggle_i;
    logic [SEL_W-1:0] tap_sel_o;
    logic             busy_o;
    logic             done_o;
    logic             locked_o;
    logic [CNT_W-1:0] measured_count_o;

    modport master (
        output start_i, target_count_i, osc_toggle_i,
        input  tap_sel_o, busy_o, done_o, locked_o, measured_count_o
    );

    modport slave (
        input  start_i, target_count_i, osc_toggle_i,
        output tap_sel_o, busy_o, done_o, locked_o, measured_count_o
    );
endinterface

// File: rtl/clk_gen_tune_ctrl.sv
// Ring-oscillator calibration: binary search over the stage-select code for the slowest
// tap whose edge count per reference window still meets the target, then a verify window.
module clk_gen_tune_ctrl #(
    parameter int SEL_W         = 4,
    parameter int CNT_W         = 12,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    clk_gen_tune_ctrl_if.slave bus
);
    localparam int CYC_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam int IDX_W   = (SEL_W > 1) ? $clog2(SEL_W) : 1;

    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(SEL_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_VSETTLE, S_VERIFY, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   meas_q, meas_d;
    logic               locked_q, locked_d;

    logic               osc_edge;
    logic               meets_target;
    logic [CNT_W-1:0]   cnt_inc;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
            idx_q    <= '0;
            tap_q    <= '0;
            target_q <= '0;
            meas_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            tap_q    <= tap_d;
            target_q <= target_d;
            meas_q   <= meas_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        // sync_q[0..1] form the synchronizer, sync_q[2] is the edge-detect history flop
        sync_d   = {sync_q[1:0], bus.osc_toggle_i};
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        idx_d    = idx_q;
        tap_d    = tap_q;
        target_d = target_q;
        meas_d   = meas_q;
        locked_d = locked_q;

        osc_edge     = sync_q[1] ^ sync_q[2];
        meets_target = (cnt_q >= target_q);
        cnt_inc      = (osc_edge && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                cyc_d = '0;
                if (bus.start_i) begin
                    target_d          = bus.target_count_i;
                    tap_d             = '0;
                    tap_d[SEL_W-1]    = 1'b1;
                    idx_d             = IDX_TOP;
                    locked_d          = 1'b0;
                    state_d           = S_SETTLE;
                end
            end
            S_SETTLE, S_VSETTLE: begin
                cnt_d = '0;
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = (state_q == S_SETTLE) ? S_MEASURE : S_VERIFY;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_MEASURE, S_VERIFY: begin
                cnt_d = cnt_inc;
                if (cyc_q == WINDOW_LAST) begin
                    cyc_d   = '0;
                    state_d = (state_q == S_MEASURE) ? S_DECIDE : S_DONE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_DECIDE: begin
                meas_d = cnt_q;
                // Too few edges means the loop is too long: drop this stage bit
                if (!meets_target) begin
                    tap_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    tap_d[idx_q - IDX_W'(1)] = 1'b1;
                    idx_d                    = idx_q - IDX_W'(1);
                    state_d                  = S_SETTLE;
                end else begin
                    state_d = S_VSETTLE;
                end
            end
            S_DONE: begin
                meas_d   = cnt_q;
                locked_d = meets_target;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tap_sel_o        = tap_q;
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.done_o           = (state_q == S_DONE);
    assign bus.locked_o         = locked_q;
    assign bus.measured_count_o = meas_q;
endmodule
